pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// multi-cycle mult/div stalls, with saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_LAT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             br_taken,
    input  logic             mdu_start,
    input  logic             perf_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_clear,
    output logic             exmem_clear,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic               r_mdu_busy;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_load_use;

    // A load targeting $zero never creates a dependency.
    assign w_load_use = ex_memread & (ex_rt != 5'd0) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mdu_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mdu_busy <= (w_state_nxt == ST_MDU_WAIT);
        end
    end

    // Mealy control: taken branch dominates, then MDU wait, then load-use.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        pc_we          = 1'b1;
        ifid_we        = 1'b1;
        ifid_flush     = 1'b0;
        idex_clear     = 1'b0;
        exmem_clear    = 1'b0;
        if (!rst_n) begin
            pc_we          = 1'b0;
            ifid_we        = 1'b0;
            ifid_flush     = 1'b1;
            idex_clear     = 1'b1;
            exmem_clear    = 1'b1;
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
        end else if (br_taken) begin
            ifid_flush     = 1'b1;
            idex_clear     = 1'b1;
            exmem_clear    = 1'b1;
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_clear = 1'b1;
                    end else if (mdu_start) begin
                        w_state_nxt    = ST_MDU_WAIT;
                        w_wait_cnt_nxt = WAIT_W'(MDU_LAT - 1);
                    end
                end
                ST_MDU_WAIT: begin
                    pc_we          = 1'b0;
                    ifid_we        = 1'b0;
                    idex_clear     = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
                    if (r_wait_cnt <= WAIT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (br_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign mdu_busy  = r_mdu_busy;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a cycle-count model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, br_taken, mdu_start, perf_clr;
    logic             pc_we, ifid_we, ifid_flush, idex_clear, exmem_clear, mdu_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model: stall cycles still owed to the MDU, plus plain counters.
    int m_wait  = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_wait_nxt;
    logic e_pc_we, e_ifid_we, e_ifid_flush, e_idex_clear, e_exmem_clear;

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .br_taken(br_taken), .mdu_start(mdu_start), .perf_clr(perf_clr),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_clear(idex_clear), .exmem_clear(exmem_clear), .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0;
        br_taken = 1'b0; mdu_start = 1'b0; perf_clr = 1'b0;
    endtask

    // Settle after input changes, derive expected outputs, compare everything.
    task automatic cmp();
        bit lu;
        #1;
        if (!rst_n) begin
            m_wait = 0; m_stall = 0; m_flush = 0;
        end
        lu = ex_memread && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        m_wait_nxt = m_wait;
        {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_clear, e_exmem_clear} = 5'b11000;
        if (!rst_n) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_clear, e_exmem_clear} = 5'b00111;
            m_wait_nxt = 0;
        end else if (br_taken) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_clear, e_exmem_clear} = 5'b11111;
            m_wait_nxt = 0;
        end else if (m_wait > 0) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_clear, e_exmem_clear} = 5'b00010;
            m_wait_nxt = m_wait - 1;
        end else if (lu) begin
            {e_pc_we, e_ifid_we, e_ifid_flush, e_idex_clear, e_exmem_clear} = 5'b00010;
        end else if (mdu_start) begin
            m_wait_nxt = MDU_LAT - 1;
        end
        chk("pc_we",       int'(pc_we),       int'(e_pc_we));
        chk("ifid_we",     int'(ifid_we),     int'(e_ifid_we));
        chk("ifid_flush",  int'(ifid_flush),  int'(e_ifid_flush));
        chk("idex_clear",  int'(idex_clear),  int'(e_idex_clear));
        chk("exmem_clear", int'(exmem_clear), int'(e_exmem_clear));
        chk("mdu_busy",    int'(mdu_busy),    (m_wait > 0) ? 1 : 0);
        chk("stall_cnt",   int'(stall_cnt),   m_stall);
        chk("flush_cnt",   int'(flush_cnt),   m_flush);
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) begin
            m_wait = m_wait_nxt;
            if (perf_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e_pc_we && m_stall < SAT) m_stall++;
                if (br_taken && m_flush < SAT) m_flush++;
            end
        end
        #1;
    endtask

    task automatic cyc();
        cmp();
        adv();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cmp();
        chk("rst_pc_we", int'(pc_we), 0);
        chk("rst_ifid_flush", int'(ifid_flush), 1);
        adv();
        rst_n = 1'b1;
        cyc();

        // Load-use on rs
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cmp();
        chk("lu_pc_we", int'(pc_we), 0);
        chk("lu_idex_clear", int'(idex_clear), 1);
        adv();
        chk("lu_stall_cnt", int'(stall_cnt), 1);

        // $zero destination is exempt
        ex_rt = 5'd0; id_rs = 5'd0;
        cmp();
        chk("zero_pc_we", int'(pc_we), 1);
        adv();

        // MDU issue: three stall cycles with MDU_LAT=4
        idle(); perf_clr = 1'b1; cyc();
        perf_clr = 1'b0; mdu_start = 1'b1;
        cmp();
        chk("mdu_issue_pc_we", int'(pc_we), 1);
        adv();
        chk("mdu_busy_set", int'(mdu_busy), 1);
        mdu_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmp();
            chk("mdu_wait_pc_we", int'(pc_we), 0);
            adv();
        end
        chk("mdu_busy_done", int'(mdu_busy), 0);
        chk("mdu_stall_cnt", int'(stall_cnt), 3);

        // Branch beats load-use and mdu_start together
        idle(); perf_clr = 1'b1; cyc();
        perf_clr = 1'b0; br_taken = 1'b1; mdu_start = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cmp();
        chk("br_pc_we", int'(pc_we), 1);
        chk("br_exmem_clear", int'(exmem_clear), 1);
        adv();
        chk("br_busy", int'(mdu_busy), 0);
        chk("br_flush_cnt", int'(flush_cnt), 1);

        // Abort on second wait cycle
        idle(); mdu_start = 1'b1; cyc();
        mdu_start = 1'b0; cyc();
        br_taken = 1'b1;
        cmp();
        chk("abort_ifid_flush", int'(ifid_flush), 1);
        adv();
        chk("abort_busy", int'(mdu_busy), 0);
        br_taken = 1'b0; cyc();

        // Reset asserted mid-wait drops busy immediately
        mdu_start = 1'b1; cyc();
        mdu_start = 1'b0; cyc();
        rst_n = 1'b0;
        cmp();
        chk("rst_mid_busy", int'(mdu_busy), 0);
        adv();
        rst_n = 1'b1; cyc();

        // Saturation then clear
        ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stall_cnt", int'(stall_cnt), 15);
        idle(); perf_clr = 1'b1; cyc();
        chk("clr_stall_cnt", int'(stall_cnt), 0);
        perf_clr = 1'b0;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            mdu_start  = ($urandom_range(0, 5) == 0);
            perf_clr   = ($urandom_range(0, 39) == 0);
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_rt      = 5'($urandom_range(0, 7));
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            cyc();
        end
        rst_n = 1'b1; idle();
        cmp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
